// File: rtl/d_cmp_iter_if.sv
// Request/result bundle for d_cmp_iter: operands and mode in, handshake and results out.
interface d_cmp_iter_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic             cond;
    logic             zero;
    logic [CW-1:0]    popcnt;
    logic             flag;

    modport master (
        output start, mode, rs_data, rt_data,
        input  busy, done, cond, zero, popcnt, flag
    );

    modport slave (
        input  start, mode, rs_data, rt_data,
        output busy, done, cond, zero, popcnt, flag
    );
endinterface

// File: rtl/d_cmp_iter.sv
// Iterative compare/popcount unit: STEP bits of A per cycle, optional divisibility flag.
// Define D_CMP_ITER_FLAG_EN to build the CHECK state and the flag result; otherwise flag is 0.
module d_cmp_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    d_cmp_iter_if.slave bus
);
    localparam int unsigned CW     = $clog2(WIDTH + 1);
    localparam int unsigned NSLICE = WIDTH / STEP;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SW     = $clog2(STEP + 1);

`ifdef D_CMP_ITER_FLAG_EN
    typedef enum logic [1:0] {IDLE, COUNT, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       mode_q;
    logic [CW-1:0]    acc_q, acc_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic [SW-1:0]    slice_ones;
    logic             load_res;
    logic             cond_c;
    logic             busy_q, done_q, cond_q, zero_q;
    logic [CW-1:0]    popcnt_q;
`ifdef D_CMP_ITER_FLAG_EN
    logic [CW-1:0]    rem_q, rem_n;
    logic             flag_q, flag_n;
`endif

    function automatic logic [SW-1:0] ones(input logic [STEP-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(STEP); i++) n = n + SW'(v[i]);
        return n;
    endfunction

    assign slice_ones = ones(a_q[int'(idx_q) * int'(STEP) +: STEP]);

    // Branch condition over the latched operands
    always_comb begin
        cond_c = 1'b0;
        unique case (mode_q)
            3'b000:  cond_c = (a_q == b_q);
            3'b001:  cond_c = (a_q != b_q);
            3'b010:  cond_c = a_q[WIDTH-1] | (a_q == '0);
            3'b011:  cond_c = ~a_q[WIDTH-1] & (a_q != '0);
            3'b100:  cond_c = a_q[WIDTH-1];
            3'b101:  cond_c = ~a_q[WIDTH-1];
            3'b110:  cond_c = ($signed(a_q) < $signed(b_q));
            default: cond_c = (a_q < b_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and datapath updates
    always_comb begin
        state_n  = state;
        acc_n    = acc_q;
        idx_n    = idx_q;
        load_res = 1'b0;
`ifdef D_CMP_ITER_FLAG_EN
        rem_n    = rem_q;
        flag_n   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = COUNT;
                    acc_n   = '0;
                    idx_n   = '0;
`ifdef D_CMP_ITER_FLAG_EN
                    rem_n   = '0;
`endif
                end
            end
            COUNT: begin
                acc_n = acc_q + CW'(slice_ones);
                idx_n = idx_q + IW'(1);
                if (idx_q == IW'(NSLICE - 1)) begin
`ifdef D_CMP_ITER_FLAG_EN
                    if (acc_n == '0) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                    end else begin
                        rem_n   = CW'(WIDTH) - acc_n;
                        state_n = CHECK;
                    end
`else
                    state_n  = DONE;
                    load_res = 1'b1;
`endif
                end
            end
`ifdef D_CMP_ITER_FLAG_EN
            CHECK: begin
                if (rem_q >= acc_q) begin
                    rem_n = rem_q - acc_q;
                end else begin
                    flag_n   = (rem_q == '0);
                    state_n  = DONE;
                    load_res = 1'b1;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, working registers and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cond_q   <= 1'b0;
            zero_q   <= 1'b0;
            popcnt_q <= '0;
`ifdef D_CMP_ITER_FLAG_EN
            rem_q    <= '0;
            flag_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.start) begin
                a_q    <= bus.rs_data;
                b_q    <= bus.rt_data;
                mode_q <= bus.mode;
            end
            acc_q  <= acc_n;
            idx_q  <= idx_n;
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);
            if (load_res) begin
                cond_q   <= cond_c;
                zero_q   <= (a_q == b_q);
                popcnt_q <= acc_n;
`ifdef D_CMP_ITER_FLAG_EN
                flag_q   <= flag_n;
`endif
            end
`ifdef D_CMP_ITER_FLAG_EN
            rem_q <= rem_n;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cond   = cond_q;
    assign bus.zero   = zero_q;
    assign bus.popcnt = popcnt_q;
`ifdef D_CMP_ITER_FLAG_EN
    assign bus.flag   = flag_q;
`else
    assign bus.flag   = 1'b0;
`endif
endmodule

// File: doc/d_cmp_iter.md
D_CMP_ITER -- requirements
Module: d_cmp_iter

Interface
REQ-001 Parameter WIDTH, 32, operand width; SHALL be a multiple of STEP and at least 2.
REQ-002 Parameter STEP, 4, operand bits popcounted per COUNT cycle.
REQ-003 Let CW = $clog2(WIDTH+1), the width of the popcount result.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; accepted only in IDLE.
REQ-007 mode  input  3  condition select, sampled on accept.
REQ-008 rs_data  input  WIDTH  operand A, sampled on accept.
REQ-009 rt_data  input  WIDTH  operand B, sampled on accept.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking the cycle results become valid.
REQ-012 cond  output  1  branch condition result.
REQ-013 zero  output  1  high when A equals B.
REQ-014 popcnt  output  CW  number of ones in A.
REQ-015 flag  output  1  high when popcnt is nonzero and (WIDTH - popcnt) mod popcnt = 0.

Function
REQ-016 States SHALL be IDLE, COUNT, CHECK and DONE.
REQ-017 IDLE with start high SHALL latch A, B and mode, clear the accumulator and remainder, and go to COUNT.
REQ-018 In IDLE with start low, the block SHALL stay in IDLE.
REQ-019 start SHALL be ignored while busy.
REQ-020 COUNT SHALL add the ones of slice k of A (bits STEP*k .. STEP*k+STEP-1, LSB slice first) each cycle.
REQ-021 COUNT SHALL last exactly WIDTH/STEP cycles: 8 cycles at the default parameters.
REQ-022 Leaving COUNT, if the count is 0 the block SHALL go straight to DONE with flag 0.
REQ-023 Leaving COUNT with a nonzero count, the block SHALL load rem = WIDTH - count and go to CHECK.
REQ-024 CHECK SHALL subtract count from rem once per cycle while rem >= count.
REQ-025 When rem < count, CHECK SHALL set flag = (rem == 0) and go to DONE.
REQ-026 Worst-case CHECK length SHALL be WIDTH cycles (count = 1).
REQ-027 cond SHALL be computed from the latched operands per mode:
- 000 A==B
- 001 A!=B
- 010 signed A<=0
- 011 signed A>0
- 100 signed A<0
- 101 signed A>=0
- 110 signed A<B
- 111 unsigned A<B
REQ-028 DONE SHALL last one cycle with done=1.
REQ-029 cond, zero, popcnt and flag SHALL update only in the DONE cycle and hold until the next DONE.
REQ-030 DONE SHALL return to IDLE.
REQ-031 A start in the DONE cycle SHALL be ignored; accept is possible from the following IDLE cycle.
REQ-032 Arithmetic SHALL NOT overflow: the accumulator is CW bits and the all-ones case gives count = WIDTH, rem = 0, flag = 1.

Reset
REQ-033 reset high SHALL asynchronously force IDLE from any state, including mid-COUNT and mid-CHECK.
REQ-034 reset SHALL drive busy, done, cond, zero, popcnt and flag to 0, and clear all internal registers.
REQ-035 The first accept after reset deasserts SHALL be possible on the first clk edge with start high.

Configuration
REQ-036 With macro D_CMP_ITER_FLAG_EN defined, CHECK and flag SHALL behave per REQ-022..REQ-026.
REQ-037 Without D_CMP_ITER_FLAG_EN:
- CHECK and the rem register SHALL be absent;
- COUNT SHALL go directly to DONE;
- flag SHALL be constant 0;
- latency SHALL be fixed at WIDTH/STEP + 1 cycles after accept.

Verification
REQ-038 WIDTH=32, STEP=4, A=B=0x0000000F, mode 000 -> DONE after 8 COUNT + 8 CHECK cycles; cond=1, zero=1, popcnt=4, flag=1.
REQ-039 A=0x00000007, B=0, mode 001 -> popcnt=3, flag=0 (29 mod 3 = 2), cond=1, zero=0.
REQ-040 Two runs -> two results:
- A=0, mode 101 -> CHECK skipped, done 9 cycles after accept, popcnt=0, flag=0, cond=1;
- A=0xFFFFFFFF -> popcnt=32, flag=1.
REQ-041 A=0xFFFFFFFF, B=1 -> mode 110 gives cond=1; mode 111 gives cond=0.
REQ-042 Disturbances:
- start pulsed during COUNT -> ignored, results unchanged;
- reset asserted mid-COUNT -> next cycle busy=0, all outputs 0, then a fresh start completes normally.
